// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared FSM encoding and defaults for the blocking switch read path
package io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } io_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 20;

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - 2-FF synchronizer, counting debouncer and rising-edge strobe for one key
module io_debounce
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_in,
   output logic press
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             stable;
   logic             stable_q;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         stable   <= 1'b0;
         stable_q <= 1'b0;
         count    <= '0;
      end else begin
         sync_1   <= raw_in;
         sync_2   <= sync_1;
         stable_q <= stable;
         // Any cycle of agreement restarts the run, so bounces never accumulate.
         if (sync_2 == stable) begin
            count <= '0;
         end else if (count == CNT_LAST) begin
            stable <= sync_2;
            count  <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

   assign press = stable & ~stable_q;

endmodule

// File: rtl/ioread_ctrl.sv
// rtl/ioread_ctrl.sv - blocking CPU input read: arm on request, capture switches on debounced confirm press
module ioread_ctrl
   import io_pkg::*;
#(
   parameter int DATA_W          = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ior_req,
   input  logic [DATA_W-1:0] switch_in,
   input  logic              key_in,
   output logic [DATA_W-1:0] ioread_data,
   output logic              io_ready,
   output logic              busy
);

   logic [DATA_W-1:0] sw_sync_1;
   logic [DATA_W-1:0] sw_sync_2;
   logic              key_press;
   logic              capture;
   io_state_t         state;
   io_state_t         state_nxt;

   io_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clock  (clock),
      .reset  (reset),
      .raw_in (key_in),
      .press  (key_press)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         sw_sync_1   <= '0;
         sw_sync_2   <= '0;
         ioread_data <= '0;
         state       <= IDLE;
      end else begin
         sw_sync_1 <= switch_in;
         sw_sync_2 <= sw_sync_1;
         state     <= state_nxt;
         if (capture) begin
            ioread_data <= sw_sync_2;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (ior_req) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            // A dropped request wins over a press landing in the same cycle.
            if (!ior_req) begin
               state_nxt = IDLE;
            end else if (key_press) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy     = (state == ARMED);
   assign io_ready = (state == DONE);

endmodule

// File: tb/tb_ioread_ctrl.sv
// tb/tb_ioread_ctrl.sv - directed self-checking bench for ioread_ctrl with a 4-cycle debounce
module tb_ioread_ctrl;

   localparam int DW  = 4;
   localparam int DEB = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          ior_req = 1'b0;
   logic [DW-1:0] switch_in = '0;
   logic          key_in = 1'b0;
   logic [DW-1:0] ioread_data;
   logic          io_ready;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   ioread_ctrl #(
      .DATA_W          (DW),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ior_req     (ior_req),
      .switch_in   (switch_in),
      .key_in      (key_in),
      .ioread_data (ioread_data),
      .io_ready    (io_ready),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Idle for n edges expecting no ready pulse, a fixed busy level and unchanged data.
   task automatic quiet(input string tag, input int n, input logic exp_busy, input logic [DW-1:0] exp_data);
      for (int i = 0; i < n; i++) begin
         tick();
         check({tag, "_rdy"}, 8'(io_ready), 8'h0);
         check({tag, "_busy"}, 8'(busy), 8'(exp_busy));
      end
      check({tag, "_data"}, 8'(ioread_data), 8'(exp_data));
   endtask

   // Assumes FSM already ARMED and key stable low; press and expect capture at edge DEB+3.
   task automatic press_and_capture(input string tag, input logic [DW-1:0] exp_data);
      key_in = 1'b1;
      for (int e = 1; e <= DEB + 3; e++) begin
         tick();
         check({tag, "_rdy"}, 8'(io_ready), 8'(e == DEB + 3));
      end
      check({tag, "_data"}, 8'(ioread_data), 8'(exp_data));
      check({tag, "_busy_done"}, 8'(busy), 8'h0);
      ior_req = 1'b0;
      tick();
      check({tag, "_rdy_after"}, 8'(io_ready), 8'h0);
      check({tag, "_hold"}, 8'(ioread_data), 8'(exp_data));
      key_in = 1'b0;
      quiet({tag, "_rel"}, DEB + 4, 1'b0, exp_data);
   endtask

   initial begin
      // 1: reset holds everything at zero despite active inputs
      reset = 1'b0; switch_in = 4'hA; key_in = 1'b1; ior_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_data", 8'(ioread_data), 8'h0);
         check("rst_rdy", 8'(io_ready), 8'h0);
         check("rst_busy", 8'(busy), 8'h0);
      end
      key_in = 1'b0; ior_req = 1'b0;
      reset = 1'b1;
      quiet("post_rst", 3, 1'b0, 4'h0);

      // 2: normal read of 4'h5
      switch_in = 4'h5; ior_req = 1'b1;
      key_in = 1'b1;
      for (int e = 1; e <= DEB + 3; e++) begin
         tick();
         if (e == 1) check("n_busy", 8'(busy), 8'h1);
         check("n_rdy", 8'(io_ready), 8'(e == DEB + 3));
      end
      check("n_data", 8'(ioread_data), 8'h5);
      ior_req = 1'b0;
      tick();
      check("n_rdy_once", 8'(io_ready), 8'h0);
      check("n_idle", 8'(busy), 8'h0);
      key_in = 1'b0;
      quiet("n_rel", DEB + 4, 1'b0, 4'h5);

      // 3: bounce shorter than the debounce window is rejected
      switch_in = 4'h9; ior_req = 1'b1;
      tick();
      check("b_busy", 8'(busy), 8'h1);
      for (int i = 0; i < 12; i++) begin
         key_in = ((i / 2) % 2 == 0);
         tick();
         check("b_rdy", 8'(io_ready), 8'h0);
         check("b_busy", 8'(busy), 8'h1);
      end
      key_in = 1'b0;
      quiet("b_tail", 6, 1'b1, 4'h5);

      // 5: abort, then a press while idle produces nothing
      switch_in = 4'hF; ior_req = 1'b0;
      tick();
      check("a_busy", 8'(busy), 8'h0);
      key_in = 1'b1;
      quiet("a_press", 10, 1'b0, 4'h5);
      key_in = 1'b0;
      quiet("a_rel", DEB + 4, 1'b0, 4'h5);

      // 4: key already held when arming; needs release and a fresh press
      key_in = 1'b1;
      quiet("h_hold", 20, 1'b0, 4'h5);
      ior_req = 1'b1;
      quiet("h_armed", 8, 1'b1, 4'h5);
      switch_in = 4'hC; key_in = 1'b0;
      quiet("h_release", 8, 1'b1, 4'h5);
      press_and_capture("h_repress", 4'hC);

      // 6: reset while armed and debouncing aborts silently; next request works
      switch_in = 4'h6; ior_req = 1'b1;
      tick();
      check("r_busy", 8'(busy), 8'h1);
      key_in = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         check("r_rdy_pre", 8'(io_ready), 8'h0);
      end
      reset = 1'b0;
      tick();
      check("r_busy_rst", 8'(busy), 8'h0);
      check("r_rdy_rst", 8'(io_ready), 8'h0);
      check("r_data_rst", 8'(ioread_data), 8'h0);
      reset = 1'b1; key_in = 1'b0; ior_req = 1'b0;
      quiet("r_after", 8, 1'b0, 4'h0);
      ior_req = 1'b1;
      tick();
      check("r_rearm", 8'(busy), 8'h1);
      press_and_capture("r_read", 4'h6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
